// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the memory responder.
// State encoding, data word width and index-width helper.
package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Number of word-index bits needed to address a power-of-two depth.
    function automatic int idx_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous word RAM.
// Read data is registered every cycle from the presented address; a write
// commits on the same edge. Contents are never reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Synchronous write and registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: one-outstanding-request memory slave with fixed wait states.
// IDLE accepts, WAIT burns WAIT_CYCLES cycles, RESP presents the result until
// the initiator takes it. The array is touched only on the edge entering RESP.
// Optional feature: define MEM_ERR_CHECK_EN to reject misaligned and
// out-of-range addresses (resp_err=1, no write, same timing).
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IW = idx_width(DEPTH_WORDS);

    state_t            state;
    logic [3:0]        cnt;
    logic              wr_q;
    logic              err_q;
    logic [IW-1:0]     idx_q;
    logic [WORD_W-1:0] wdata_q;

    logic              accept;
    logic              enter_resp;
    logic              req_err;
    logic [IW-1:0]     req_idx;
    logic              cur_wr;
    logic              cur_err;
    logic [IW-1:0]     ram_addr;
    logic [WORD_W-1:0] ram_wdata;
    logic              ram_we;
    logic [WORD_W-1:0] ram_rdata;

    assign req_idx = req_addr[IW+1:2];

`ifdef MEM_ERR_CHECK_EN
    // Misaligned, or beyond the last word (upper bits above the index set).
    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:IW+2] != '0);
`else
    // Low and high address bits are don't-care; the index simply wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:IW+2], req_addr[1:0]};
    assign req_err = 1'b0;
`endif

    // req_ready is only ever high in IDLE, so this is the acceptance edge.
    assign accept     = req_valid && req_ready;
    assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                        ((state == WAIT) && (cnt == 4'd0));

    // With zero wait states the access happens on the acceptance edge itself,
    // so the live request is used; otherwise the captured copy is.
    assign cur_wr    = accept ? req_write : wr_q;
    assign cur_err   = accept ? req_err   : err_q;
    assign ram_addr  = accept ? req_idx   : idx_q;
    assign ram_wdata = accept ? req_wdata : wdata_q;
    assign ram_we    = enter_resp && cur_wr && !cur_err;

    mem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (IW)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // ram_rdata is registered on the RESP entry edge and idx_q is frozen, so
    // the gated value is stable for the whole RESP phase.
    assign resp_rdata = (resp_valid && !wr_q && !err_q) ? ram_rdata : '0;
    assign resp_err   = resp_valid && err_q;

    // Request FSM with wait counter and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        wr_q      <= req_write;
                        err_q     <= req_err;
                        idx_q     <= req_idx;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule
